cal_time_set_ctrl: RTL and testbench
====================================

// Module: cal_time_set_ctrl
// PURPOSE
// - Key-driven set-mode controller for the perpetual-calendar time base.
// - Snapshots current calendar time and walks the user through each field: year, month, day, week, hour, min, sec.
// - Supports inc/dec with wrap and month/leap-aware day clamping.
// - Commits by driving the *_set buses plus a one-cycle time_set pulse into the calendar counter chain.
// PARAMETERS
// - TIMEOUT_CYC  6000  idle cycles in any set state before auto-abort (0 disables)
// - YEAR_MIN     2000  lowest settable year; wrap target
// - YEAR_MAX     2199  highest settable year
// PORTS
// - clk          in   1   system clock
// - rst          in   1   reset; asynchronous, active-high
// - key_mode     in   1   debounced 1-cycle pulse: enter set mode / advance field
// - key_inc      in   1   debounced 1-cycle pulse: increment selected field
// - key_dec      in   1   debounced 1-cycle pulse: decrement selected field
// - key_cancel   in   1   debounced 1-cycle pulse: abort without commit
// - cur_year/mon/week/day/hour/min/sec  in  12/4/3/5/5/6/6  live calendar values
// - year_set/mon_set/week_set/day_set/hour_set/min_set/sec_set  out  12/4/3/5/5/6/6  shadow values to load
// - time_set     out  1   registered 1-cycle load strobe to calendar chain
// - setting      out  1   high while in any S_* state (display freeze/blink)
// - field        out  3   selected field: 0 none, 1 yr, 2 mon, 3 day, 4 wk, 5 hr, 6 min, 7 sec
// BEHAVIOUR
// - Reset values:
//   - state RUN; time_set=0, setting=0, field=0.
//   - Shadows: year 2000, mon 1, day 1, week 6, hour/min/sec 0.
// - FSM: RUN -> S_YEAR -> S_MON -> S_DAY -> S_WEEK -> S_HOUR -> S_MIN -> S_SEC -> COMMIT -> RUN.
// - RUN:
//   - key_mode: copy all cur_* into shadows in that edge, go S_YEAR.
//   - inc/dec/cancel ignored.
// - S_* states:
//   - key_mode advances to the next state; from S_SEC it goes to COMMIT.
//   - key_cancel goes to RUN; shadows kept, no strobe.
//   - Cancel wins over mode; mode wins over inc/dec.
//   - inc and dec together: no change.
// - Wrap rules:
//   - Increment: year YEAR_MAX->YEAR_MIN; mon 12->1; day maxday->1; week 7->1; hour 23->0; min 59->0; sec 59->0.
//   - Decrement is the exact inverse: 1->maxday, 1->12, 1->7, 0->23, 0->59.
// - maxday:
//   - 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11.
//   - Feb: 29 if leap, else 28.
//   - leap = (y%4==0 && y%100!=0) || y%400==0; 2000 is leap, 2100 is not.
// - Clamp: when leaving S_YEAR or S_MON, if day_set > maxday(new yr, mon) then day_set=maxday. Applied on the transition edge.
// - COMMIT:
//   - time_set=1 for exactly one cycle with shadows stable; then RUN.
//   - All keys ignored in COMMIT.
// - Hold: shadows and *_set stay stable after commit/cancel until the next entry.
// - setting: 1 in S_YEAR..S_SEC only; field tracks state, 0 in RUN/COMMIT.
// - Timeout: counter clears on any key pulse and on state entry. Reaching TIMEOUT_CYC in S_* means abort to RUN, as for cancel.
// - Async rst mid-set or mid-COMMIT: immediate return to reset values; no strobe emitted.
// - Latency: key pulse to state/shadow change is 1 clk; mode in S_SEC to time_set high is 1 clk (time_set asserted in the cycle after).
// - All outputs come from registers (time_set feeds edge-sensitive logic; must be glitch-free).
// STRUCTURE
// - Package cal_pkg:
//   - state enum and field codes (FLD_*).
//   - YEAR_MIN/YEAR_MAX defaults.
//   - function is_leap(y), function days_in_month(y,m).
// - Sub-module cal_field_step: combinational inc/dec with wrap.
//   - Ports: val, lo, hi, inc, dec -> nxt.
//   - One instance muxed on field; widths sized to 12 bits.
// - Top: FSM, shadow registers, clamp logic, timeout counter, strobe register.
// TESTING
// - Reset, then mode: cur=2024/02/29 wk4 13:45:30 -> shadows equal cur, field=1, setting=1.
// - Wrap: in S_YEAR at 2199, inc -> 2000. In S_HOUR at 0, dec -> 23. In S_SEC at 59, inc -> 0.
// - Clamp: day 31, mon 1, then S_MON inc -> mon 2 in 2023. Leaving S_MON -> day 28; with 2024 -> day 29; with 2100 -> day 28.
// - Commit: step mode through all 8 states -> time_set high exactly 1 cycle; *_set hold entered values; setting=0.
// - Cancel and timeout (TIMEOUT_CYC=16): cancel in S_DAY -> RUN, no strobe; 16 idle cycles in S_MIN -> RUN, no strobe.
// - Async rst asserted during COMMIT cycle -> time_set=0 immediately; shadows back to 2000/1/1/6/00:00:00.

Source files
------------

// File: rtl/cal_pkg.sv
// Shared types and calendar helpers for the time-set controller.
package cal_pkg;

   localparam int unsigned YEAR_MIN_DEF = 2000;
   localparam int unsigned YEAR_MAX_DEF = 2199;

   typedef enum logic [3:0] {
      ST_RUN    = 4'd0,
      ST_YEAR   = 4'd1,
      ST_MON    = 4'd2,
      ST_DAY    = 4'd3,
      ST_WEEK   = 4'd4,
      ST_HOUR   = 4'd5,
      ST_MIN    = 4'd6,
      ST_SEC    = 4'd7,
      ST_COMMIT = 4'd8
   } state_t;

   localparam logic [2:0] FLD_NONE = 3'd0;
   localparam logic [2:0] FLD_YEAR = 3'd1;
   localparam logic [2:0] FLD_MON  = 3'd2;
   localparam logic [2:0] FLD_DAY  = 3'd3;
   localparam logic [2:0] FLD_WEEK = 3'd4;
   localparam logic [2:0] FLD_HOUR = 3'd5;
   localparam logic [2:0] FLD_MIN  = 3'd6;
   localparam logic [2:0] FLD_SEC  = 3'd7;

   function automatic logic is_leap(input logic [11:0] y);
      logic leap;
      leap = ((y[1:0] == 2'b00) && ((y % 12'd100) != 12'd0)) || ((y % 12'd400) == 12'd0);
      return leap;
   endfunction

   function automatic logic [4:0] days_in_month(input logic [11:0] y, input logic [3:0] m);
      logic [4:0] d;
      d = 5'd31;
      case (m)
         4'd2:                    d = is_leap(y) ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
         default:                 d = 5'd31;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/cal_field_step.sv
// Combinational increment/decrement of one field with wrap between lo and hi.
module cal_field_step (
   input  logic [11:0] val,
   input  logic [11:0] lo,
   input  logic [11:0] hi,
   input  logic        inc,
   input  logic        dec,
   output logic [11:0] nxt
);

   always_comb begin
      nxt = val;
      if (inc && !dec) begin
         nxt = (val >= hi) ? lo : val + 12'd1;
      end else if (dec && !inc) begin
         nxt = (val <= lo) ? hi : val - 12'd1;
      end
   end

endmodule

// File: rtl/cal_time_set_ctrl.sv
// Key-driven set-mode controller: snapshots live time, edits fields, commits with a load strobe.
module cal_time_set_ctrl
   import cal_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 6000,
   parameter int unsigned YEAR_MIN    = YEAR_MIN_DEF,
   parameter int unsigned YEAR_MAX    = YEAR_MAX_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_mode,
   input  logic        key_inc,
   input  logic        key_dec,
   input  logic        key_cancel,
   input  logic [11:0] cur_year,
   input  logic [3:0]  cur_mon,
   input  logic [2:0]  cur_week,
   input  logic [4:0]  cur_day,
   input  logic [4:0]  cur_hour,
   input  logic [5:0]  cur_min,
   input  logic [5:0]  cur_sec,
   output logic [11:0] year_set,
   output logic [3:0]  mon_set,
   output logic [2:0]  week_set,
   output logic [4:0]  day_set,
   output logic [4:0]  hour_set,
   output logic [5:0]  min_set,
   output logic [5:0]  sec_set,
   output logic        time_set,
   output logic        setting,
   output logic [2:0]  field
);

   localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

   state_t        state;
   logic [TW-1:0] tmo_cnt;
   logic [11:0]   step_val;
   logic [11:0]   step_lo;
   logic [11:0]   step_hi;
   logic [11:0]   step_nxt;
   logic [4:0]    max_day;
   logic          any_key;

   assign max_day = days_in_month(year_set, mon_set);
   assign any_key = key_mode | key_inc | key_dec | key_cancel;

   // Select the field currently being edited and its legal range.
   always_comb begin
      step_val = 12'd0;
      step_lo  = 12'd0;
      step_hi  = 12'd0;
      case (state)
         ST_YEAR: begin step_val = year_set;       step_lo = 12'(YEAR_MIN); step_hi = 12'(YEAR_MAX); end
         ST_MON:  begin step_val = 12'(mon_set);  step_lo = 12'd1; step_hi = 12'd12;         end
         ST_DAY:  begin step_val = 12'(day_set);  step_lo = 12'd1; step_hi = 12'(max_day);   end
         ST_WEEK: begin step_val = 12'(week_set); step_lo = 12'd1; step_hi = 12'd7;          end
         ST_HOUR: begin step_val = 12'(hour_set); step_lo = 12'd0; step_hi = 12'd23;         end
         ST_MIN:  begin step_val = 12'(min_set);  step_lo = 12'd0; step_hi = 12'd59;         end
         ST_SEC:  begin step_val = 12'(sec_set);  step_lo = 12'd0; step_hi = 12'd59;         end
         default: begin step_val = 12'd0;         step_lo = 12'd0; step_hi = 12'd0;          end
      endcase
   end

   cal_field_step u_step (
      .val (step_val),
      .lo  (step_lo),
      .hi  (step_hi),
      .inc (key_inc),
      .dec (key_dec),
      .nxt (step_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_RUN;
         tmo_cnt  <= '0;
         time_set <= 1'b0;
         setting  <= 1'b0;
         field    <= FLD_NONE;
         year_set <= 12'd2000;
         mon_set  <= 4'd1;
         day_set  <= 5'd1;
         week_set <= 3'd6;
         hour_set <= 5'd0;
         min_set  <= 6'd0;
         sec_set  <= 6'd0;
      end else begin
         time_set <= 1'b0;
         case (state)
            ST_RUN: begin
               if (key_mode) begin
                  year_set <= cur_year;
                  mon_set  <= cur_mon;
                  day_set  <= cur_day;
                  week_set <= cur_week;
                  hour_set <= cur_hour;
                  min_set  <= cur_min;
                  sec_set  <= cur_sec;
                  state    <= ST_YEAR;
                  setting  <= 1'b1;
                  field    <= FLD_YEAR;
                  tmo_cnt  <= '0;
               end
            end
            ST_COMMIT: begin
               state <= ST_RUN;
            end
            ST_YEAR, ST_MON, ST_DAY, ST_WEEK, ST_HOUR, ST_MIN, ST_SEC: begin
               if (any_key) tmo_cnt <= '0;
               if (key_cancel) begin
                  state   <= ST_RUN;
                  setting <= 1'b0;
                  field   <= FLD_NONE;
               end else if (key_mode) begin
                  // Leaving year or month may shorten the month: pull day back in range.
                  if ((state == ST_YEAR || state == ST_MON) && day_set > max_day) day_set <= max_day;
                  if (state == ST_SEC) begin
                     state    <= ST_COMMIT;
                     setting  <= 1'b0;
                     field    <= FLD_NONE;
                     time_set <= 1'b1;
                  end else begin
                     state <= state_t'(state + 4'd1);
                     field <= field + 3'd1;
                  end
               end else if (key_inc || key_dec) begin
                  case (state)
                     ST_YEAR: year_set <= step_nxt;
                     ST_MON:  mon_set  <= 4'(step_nxt);
                     ST_DAY:  day_set  <= 5'(step_nxt);
                     ST_WEEK: week_set <= 3'(step_nxt);
                     ST_HOUR: hour_set <= 5'(step_nxt);
                     ST_MIN:  min_set  <= 6'(step_nxt);
                     default: sec_set  <= 6'(step_nxt);
                  endcase
               end else if (TIMEOUT_CYC != 0) begin
                  if (tmo_cnt == TMO_LAST) begin
                     state   <= ST_RUN;
                     setting <= 1'b0;
                     field   <= FLD_NONE;
                  end else begin
                     tmo_cnt <= tmo_cnt + TW'(1);
                  end
               end
            end
            default: begin
               state   <= ST_RUN;
               setting <= 1'b0;
               field   <= FLD_NONE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cal_time_set_ctrl.sv
// Bench for cal_time_set_ctrl: directed scenarios plus random key traffic against a field-level model.
module tb_cal_time_set_ctrl;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        key_mode, key_inc, key_dec, key_cancel;
   logic [11:0] cur_year;
   logic [3:0]  cur_mon;
   logic [2:0]  cur_week;
   logic [4:0]  cur_day, cur_hour;
   logic [5:0]  cur_min, cur_sec;
   logic [11:0] year_set;
   logic [3:0]  mon_set;
   logic [2:0]  week_set;
   logic [4:0]  day_set, hour_set;
   logic [5:0]  min_set, sec_set;
   logic        time_set, setting;
   logic [2:0]  field;

   int checks = 0;
   int errors = 0;

   // model: st 0 = running, 1..7 = editing that field, 8 = commit cycle
   int m_st, m_idle;
   int m_y, m_mo, m_d, m_w, m_h, m_mi, m_s;

   always #5 clk = ~clk;

   cal_time_set_ctrl #(.TIMEOUT_CYC(TMO), .YEAR_MIN(2000), .YEAR_MAX(2199)) dut (
      .clk(clk), .rst(rst),
      .key_mode(key_mode), .key_inc(key_inc), .key_dec(key_dec), .key_cancel(key_cancel),
      .cur_year(cur_year), .cur_mon(cur_mon), .cur_week(cur_week), .cur_day(cur_day),
      .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
      .year_set(year_set), .mon_set(mon_set), .week_set(week_set), .day_set(day_set),
      .hour_set(hour_set), .min_set(min_set), .sec_set(sec_set),
      .time_set(time_set), .setting(setting), .field(field)
   );

   function automatic int mdays(int y, int m);
      bit leap;
      leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
      if (m == 2) return leap ? 29 : 28;
      if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
      return 31;
   endfunction

   function automatic int wrap(int v, int lo, int hi, int d);
      int span;
      span = hi - lo + 1;
      return lo + ((v - lo + d + span) % span);
   endfunction

   task automatic model_reset();
      m_st = 0; m_idle = 0;
      m_y = 2000; m_mo = 1; m_d = 1; m_w = 6; m_h = 0; m_mi = 0; m_s = 0;
   endtask

   task automatic model_step(input bit mo, input bit in, input bit de, input bit ca);
      int d;
      if (m_st == 0) begin
         if (mo) begin
            m_y = int'(cur_year); m_mo = int'(cur_mon); m_d = int'(cur_day); m_w = int'(cur_week);
            m_h = int'(cur_hour); m_mi = int'(cur_min); m_s = int'(cur_sec);
            m_st = 1; m_idle = 0;
         end
      end else if (m_st == 8) begin
         m_st = 0;
      end else if (ca) begin
         m_st = 0;
      end else if (mo) begin
         if ((m_st == 1 || m_st == 2) && m_d > mdays(m_y, m_mo)) m_d = mdays(m_y, m_mo);
         m_st = m_st + 1;
         m_idle = 0;
      end else if (in || de) begin
         m_idle = 0;
         d = (in && !de) ? 1 : (de && !in) ? -1 : 0;
         case (m_st)
            1: m_y  = wrap(m_y, 2000, 2199, d);
            2: m_mo = wrap(m_mo, 1, 12, d);
            3: m_d  = wrap(m_d, 1, mdays(m_y, m_mo), d);
            4: m_w  = wrap(m_w, 1, 7, d);
            5: m_h  = wrap(m_h, 0, 23, d);
            6: m_mi = wrap(m_mi, 0, 59, d);
            default: m_s = wrap(m_s, 0, 59, d);
         endcase
      end else begin
         m_idle = m_idle + 1;
         if (m_idle >= TMO) m_st = 0;
      end
   endtask

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      bit editing;
      editing = (m_st >= 1 && m_st <= 7);
      chk({tag, ".year"},  12'(year_set), 12'(m_y));
      chk({tag, ".mon"},   12'(mon_set),  12'(m_mo));
      chk({tag, ".day"},   12'(day_set),  12'(m_d));
      chk({tag, ".week"},  12'(week_set), 12'(m_w));
      chk({tag, ".hour"},  12'(hour_set), 12'(m_h));
      chk({tag, ".min"},   12'(min_set),  12'(m_mi));
      chk({tag, ".sec"},   12'(sec_set),  12'(m_s));
      chk({tag, ".time_set"}, 12'(time_set), 12'(m_st == 8));
      chk({tag, ".setting"},  12'(setting),  12'(editing));
      chk({tag, ".field"},    12'(field),    editing ? 12'(m_st) : 12'd0);
   endtask

   // Called at a negedge: hold keys across one posedge, then check at the next negedge.
   task automatic step(input string tag, input bit mo, input bit in, input bit de, input bit ca);
      key_mode = mo; key_inc = in; key_dec = de; key_cancel = ca;
      @(negedge clk);
      key_mode = 1'b0; key_inc = 1'b0; key_dec = 1'b0; key_cancel = 1'b0;
      model_step(mo, in, de, ca);
      check_all(tag);
   endtask

   task automatic set_cur(input int y, input int mo, input int d, input int w,
                          input int h, input int mi, input int s);
      cur_year = 12'(y); cur_mon = 4'(mo); cur_day = 5'(d); cur_week = 3'(w);
      cur_hour = 5'(h); cur_min = 6'(mi); cur_sec = 6'(s);
   endtask

   initial begin
      int r, y, mo;
      rst = 1'b1;
      key_mode = 1'b0; key_inc = 1'b0; key_dec = 1'b0; key_cancel = 1'b0;
      set_cur(2010, 5, 5, 2, 3, 4, 5);
      model_reset();
      repeat (2) @(negedge clk);
      check_all("reset");
      rst = 1'b0;
      step("idle_run", 1'b0, 1'b1, 1'b1, 1'b1);

      // Snapshot on entry
      set_cur(2024, 2, 29, 4, 13, 45, 30);
      step("enter", 1'b1, 1'b0, 1'b0, 1'b0);
      chk("enter.year_const", year_set, 12'd2024);
      chk("enter.field_const", 12'(field), 12'd1);
      step("cancel0", 1'b0, 1'b0, 1'b0, 1'b1);

      // Wraps, then a full commit walk
      set_cur(2199, 3, 15, 7, 0, 10, 59);
      step("w_enter", 1'b1, 1'b0, 1'b0, 1'b0);
      step("w_yinc", 1'b0, 1'b1, 1'b0, 1'b0);
      chk("wrap_year_up", year_set, 12'd2000);
      step("w_ydec", 1'b0, 1'b0, 1'b1, 1'b0);
      chk("wrap_year_dn", year_set, 12'd2199);
      step("w_both", 1'b0, 1'b1, 1'b1, 1'b0);
      repeat (4) step("w_adv", 1'b1, 1'b0, 1'b0, 1'b0);
      step("w_hdec", 1'b0, 1'b0, 1'b1, 1'b0);
      chk("wrap_hour_dn", 12'(hour_set), 12'd23);
      step("w_mode_inc", 1'b1, 1'b1, 1'b0, 1'b0);
      step("w_adv2", 1'b1, 1'b0, 1'b0, 1'b0);
      step("w_sinc", 1'b0, 1'b1, 1'b0, 1'b0);
      chk("wrap_sec_up", 12'(sec_set), 12'd0);
      step("commit", 1'b1, 1'b0, 1'b0, 1'b0);
      chk("commit_strobe", 12'(time_set), 12'd1);
      step("post_commit", 1'b0, 1'b0, 1'b0, 1'b1);
      chk("commit_once", 12'(time_set), 12'd0);
      repeat (3) step("hold", 1'b0, 1'b1, 1'b0, 1'b0);

      // Day clamp when month shortens, across leap rules
      for (int k = 0; k < 3; k++) begin
         y = (k == 0) ? 2023 : (k == 1) ? 2024 : 2100;
         set_cur(y, 1, 31, 3, 8, 8, 8);
         step("c_enter", 1'b1, 1'b0, 1'b0, 1'b0);
         step("c_adv", 1'b1, 1'b0, 1'b0, 1'b0);
         step("c_minc", 1'b0, 1'b1, 1'b0, 1'b0);
         step("c_leave", 1'b1, 1'b0, 1'b0, 1'b0);
         chk("clamp_day", 12'(day_set), (k == 1) ? 12'd29 : 12'd28);
         step("c_cancel", 1'b0, 1'b0, 1'b0, 1'b1);
      end

      // Cancel in day field
      set_cur(2050, 6, 10, 1, 1, 1, 1);
      step("x_enter", 1'b1, 1'b0, 1'b0, 1'b0);
      step("x_adv", 1'b1, 1'b0, 1'b0, 1'b0);
      step("x_adv", 1'b1, 1'b0, 1'b0, 1'b0);
      step("x_dinc", 1'b0, 1'b1, 1'b0, 1'b0);
      step("x_cancel", 1'b1, 1'b0, 1'b0, 1'b1);
      chk("cancel_nostrobe", 12'(time_set), 12'd0);
      chk("cancel_kept_day", 12'(day_set), 12'd11);

      // Timeout in minute field
      step("t_enter", 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (5) step("t_adv", 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (15) step("t_idle", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("tmo_not_yet", 12'(setting), 12'd1);
      step("t_expire", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("tmo_abort", 12'(setting), 12'd0);
      chk("tmo_nostrobe", 12'(time_set), 12'd0);

      // Random traffic
      for (int i = 0; i < 2500; i++) begin
         y  = int'($urandom_range(2000, 2199));
         mo = int'($urandom_range(1, 12));
         set_cur(y, mo, int'($urandom_range(1, mdays(y, mo))), int'($urandom_range(1, 7)),
                 int'($urandom_range(0, 23)), int'($urandom_range(0, 59)), int'($urandom_range(0, 59)));
         r = int'($urandom_range(0, 99));
         if (r < 14)      step("rnd", 1'b1, 1'b0, 1'b0, 1'b0);
         else if (r < 16) step("rnd", 1'b0, 1'b0, 1'b0, 1'b1);
         else if (r < 40) step("rnd", 1'b0, 1'b1, 1'b0, 1'b0);
         else if (r < 62) step("rnd", 1'b0, 1'b0, 1'b1, 1'b0);
         else if (r < 65) step("rnd", 1'b0, 1'b1, 1'b1, 1'b0);
         else if (r < 66) step("rnd", 1'b1, 1'b1, 1'b1, 1'b1);
         else if (r < 67) repeat (int'($urandom_range(14, 18))) step("rnd_idle", 1'b0, 1'b0, 1'b0, 1'b0);
         else             step("rnd", 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // Async reset during the commit cycle
      if (m_st != 0) step("r_cancel", 1'b0, 1'b0, 1'b0, 1'b1);
      set_cur(2077, 7, 7, 5, 9, 9, 9);
      step("r_enter", 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (7) step("r_adv", 1'b1, 1'b0, 1'b0, 1'b0);
      chk("r_in_commit", 12'(time_set), 12'd1);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      chk("async_rst_year", year_set, 12'd2000);
      @(negedge clk);
      rst = 1'b0;
      check_all("rst_release");
      step("after_rst", 1'b0, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
